// File: rtl/tl_memory.sv
// MEM stage of the 5-stage MIPS pipeline: byte/half/word data memory, branch
// resolution toward IF, and the MEM/WB pipeline register.
module tl_memory #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9,
    parameter int NB_ADDR_DMEM         = 10
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic [LEN-1:0]                  i_alu_result,
    input  logic [LEN-1:0]                  i_dato2,
    input  logic [LEN-1:0]                  i_pc_branch,
    input  logic                            i_alu_zero,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [NB_ADDR_DMEM-1:0]         i_dbg_addr,
    output logic                            o_pc_src,
    output logic [LEN-1:0]                  o_pc_branch,
    output logic [LEN-1:0]                  o_rd_mem_corto,
    output logic [LEN-1:0]                  o_read_data,
    output logic [LEN-1:0]                  o_alu_result,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic                            o_misaligned,
    output logic [LEN-1:0]                  o_dbg_data
);

    localparam int NB_DEPTH = 1 << NB_ADDR_DMEM;

    logic [LEN-1:0] r_mem [NB_DEPTH];

    logic [LEN-1:0]                  r_read_data;
    logic [LEN-1:0]                  r_alu_result;
    logic [NB_ADDRESS_REGISTROS-1:0] r_write_reg;
    logic [NB_CTRL_WB-1:0]           r_ctrl_wb;
    logic                            r_misaligned;
    logic [LEN-1:0]                  r_dbg_data;

    logic                    w_mem_read;
    logic                    w_mem_write;
    logic                    w_unsigned;
    logic [1:0]              w_size;
    logic [1:0]              w_lane;
    logic [NB_ADDR_DMEM-1:0] w_word_idx;
    logic                    w_aligned;
    logic                    w_do_write;
    logic                    w_do_read;
    logic [3:0]              w_byte_en;
    logic [LEN-1:0]          w_wdata;
    logic                    w_unused_bits;

    function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lane[0];
            2'b11:   ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [LEN-1:0] f_load_extend(input logic [LEN-1:0] word,
                                                     input logic [1:0]     size,
                                                     input logic [1:0]     lane,
                                                     input logic           uns);
        logic [7:0]     b;
        logic [15:0]    h;
        logic [LEN-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {{(LEN-8){1'b0}}, b}  : {{(LEN-8){b[7]}}, b};
            2'b01:   r = uns ? {{(LEN-16){1'b0}}, h} : {{(LEN-16){h[15]}}, h};
            2'b11:   r = word;
            default: r = {LEN{1'b0}};
        endcase
        return r;
    endfunction

    assign w_mem_read    = i_ctrl_mem[0];
    assign w_mem_write   = i_ctrl_mem[1];
    assign w_size        = i_ctrl_mem[5:4];
    assign w_unsigned    = i_ctrl_mem[6];
    assign w_lane        = i_alu_result[1:0];
    assign w_word_idx    = i_alu_result[NB_ADDR_DMEM+1:2];
    assign w_aligned     = f_aligned(w_size, w_lane);
    assign w_do_write    = i_enable & w_mem_write & w_aligned & ~i_rst;
    // A store wins over a load when control sets both.
    assign w_do_read     = w_mem_read & ~w_mem_write & w_aligned;
    assign w_unused_bits = ^{i_ctrl_mem[8:7], i_alu_result[LEN-1:NB_ADDR_DMEM+2]};

    // Byte enables and lane-replicated store data for the current access size.
    always_comb begin
        w_byte_en = 4'b0000;
        w_wdata   = i_dato2;
        case (w_size)
            2'b00: begin
                w_byte_en = 4'b0001 << w_lane;
                w_wdata   = {4{i_dato2[7:0]}};
            end
            2'b01: begin
                w_byte_en = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{i_dato2[15:0]}};
            end
            2'b11:   w_byte_en = 4'b1111;
            default: w_byte_en = 4'b0000;
        endcase
    end

    // Data memory write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // MEM/WB register, including the extended load data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_read_data  <= {LEN{1'b0}};
            r_alu_result <= {LEN{1'b0}};
            r_write_reg  <= {NB_ADDRESS_REGISTROS{1'b0}};
            r_ctrl_wb    <= {NB_CTRL_WB{1'b0}};
            r_misaligned <= 1'b0;
        end else if (i_enable) begin
            r_read_data  <= w_do_read ? f_load_extend(r_mem[w_word_idx], w_size, w_lane, w_unsigned)
                                      : {LEN{1'b0}};
            r_alu_result <= i_alu_result;
            r_write_reg  <= i_write_reg;
            r_ctrl_wb    <= i_ctrl_wb;
            r_misaligned <= (w_mem_read | w_mem_write) & ~w_aligned;
        end
    end

    // Debug read port, free-running regardless of pipeline enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dbg_data <= {LEN{1'b0}};
        end else begin
            r_dbg_data <= r_mem[i_dbg_addr];
        end
    end

    assign o_pc_src       = ~i_rst & ((i_ctrl_mem[2] & i_alu_zero) | (i_ctrl_mem[3] & ~i_alu_zero));
    assign o_pc_branch    = i_pc_branch;
    assign o_rd_mem_corto = i_alu_result;
    assign o_read_data    = r_read_data;
    assign o_alu_result   = r_alu_result;
    assign o_write_reg    = r_write_reg;
    assign o_ctrl_wb      = r_ctrl_wb;
    assign o_misaligned   = r_misaligned;
    assign o_dbg_data     = r_dbg_data;

endmodule
